// File: rtl/lsu_bus_adapter_if.sv
// rtl/lsu_bus_adapter_if.sv - word bus bundle between the load/store adapter and memory
//
// Signals:
//   bus_req    request, held until bus_gnt
//   bus_we     1 = write
//   bus_addr   word-aligned byte address
//   bus_be     byte enables
//   bus_wdata  lane-replicated store data
//   bus_gnt    request accepted
//   bus_rvalid read data / write ack valid
//   bus_rdata  read word
// Modports: master (adapter side), slave (memory side).

interface lsu_bus_adapter_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// rtl/lsu_bus_adapter.sv - load/store unit bridging core memory ops to a req/gnt/rvalid word bus
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mem_read, mem_write   core access request (level, held while stall=1)
//   addr, writeData       byte address and store data
//   s_sel, ld_sel         store size / load type
//   rd_data               formatted load result, valid in the DONE cycle
//   stall                 freeze PC and register writeback
//   misaligned            one-cycle pulse, access rejected
//   bus_err               one-cycle pulse, access aborted by timeout
//   bus                   word bus (master modport)

module lsu_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [31:0]              addr,
  input  logic [31:0]              writeData,
  input  logic [1:0]               s_sel,
  input  logic [2:0]               ld_sel,
  output logic [31:0]              rd_data,
  output logic                     stall,
  output logic                     misaligned,
  output logic                     bus_err,
  lsu_bus_adapter_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  ld_sel_q;
  logic [1:0]  lo_q;

  logic        req_any;
  logic        is_half;
  logic        is_word;
  logic        aligned;
  logic        launch;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Request decode; stores take priority when both strobes are high.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (mem_write) begin
      is_half = (s_sel == 2'b01);
      is_word = s_sel[1];
    end else begin
      case (ld_sel)
        3'b000, 3'b100: is_word = 1'b0;
        3'b001, 3'b101: is_half = 1'b1;
        default:        is_word = 1'b1;
      endcase
    end
  end

  always_comb begin
    be_c    = 4'b0001 << addr[1:0];
    wdata_c = {4{writeData[7:0]}};
    if (is_word) begin
      be_c    = 4'b1111;
      wdata_c = writeData;
    end else if (is_half) begin
      be_c    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{writeData[15:0]}};
    end
  end

  assign aligned = is_word ? (addr[1:0] == 2'b00) : (is_half ? ~addr[0] : 1'b1);

  // Reset masks the combinational paths so stall/misaligned read 0 while reset is held.
  assign req_any    = (mem_read | mem_write) & ~reset;
  assign launch     = (state == IDLE) & req_any & aligned;
  assign misaligned = (state == IDLE) & req_any & ~aligned;
  assign stall      = launch | (state == REQ) | (state == WAIT);

  function automatic logic [31:0] format_load(input logic [2:0]  sel,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (sel)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= 8'd0;
      ld_sel_q      <= 3'd0;
      lo_q          <= 2'd0;
      rd_data       <= 32'd0;
      bus_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state         <= REQ;
            tmo_cnt       <= 8'd0;
            rd_data       <= 32'd0;
            ld_sel_q      <= ld_sel;
            lo_q          <= addr[1:0];
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mem_write;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= be_c;
            bus.bus_wdata <= wdata_c;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // An exhausted budget wins over a grant arriving in the same cycle.
          if (tmo_cnt == TMO_LAST) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            rd_data     <= 32'd0;
          end else if (bus.bus_gnt) begin
            state       <= WAIT;
            bus.bus_req <= 1'b0;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (bus.bus_rvalid) begin
            state <= DONE;
            if (!bus.bus_we) rd_data <= format_load(ld_sel_q, lo_q, bus.bus_rdata);
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= DONE;
            bus_err <= 1'b1;
            rd_data <= 32'd0;
          end
        end
        DONE: begin
          // Request is deliberately not sampled here so the completed access is not relaunched.
          state   <= IDLE;
          rd_data <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb/tb_lsu_bus_adapter.sv - scoreboard bench for lsu_bus_adapter with a random-latency bus responder

module tb_lsu_bus_adapter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic [1:0]  s_sel = 2'd0;
  logic [2:0]  ld_sel = 3'd0;
  logic [31:0] rd_data;
  logic        stall;
  logic        misaligned;
  logic        bus_err;

  lsu_bus_adapter_if bus_if ();

  lsu_bus_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .writeData  (writeData),
    .s_sel      (s_sel),
    .ld_sel     (ld_sel),
    .rd_data    (rd_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // kind: 0 completes normally, 1 misaligned, 2 timeout
  typedef struct {
    int          kind;
    bit          is_ld;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  typedef struct {
    int          gd;
    int          rdl;
    logic [31:0] rdata;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];

  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          man_gnt = 1'b0;
  bit          man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: access width in bytes, alignment, lane math and latency rule from plain arithmetic.
  function automatic exp_t model(input bit wr, input logic [1:0] ss, input logic [2:0] ls,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rw, input int gd, input int rdl);
    exp_t        e;
    int          size;
    int          off;
    int          k;
    bit          sgn;
    logic [31:0] m;
    logic [31:0] v;
    off = int'(a % 4);
    if (wr) size = (ss == 2'd0) ? 1 : ((ss == 2'd1) ? 2 : 4);
    else begin
      case (ls)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        default:    size = 4;
      endcase
    end
    sgn = !wr && (ls == 3'd0 || ls == 3'd1);
    e.is_ld = !wr;
    e.baddr = a - 32'(off);
    e.be    = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    m = (32'h1 << (8 * size)) - 32'h1;
    v = (rw >> (8 * off)) & m;
    if (sgn && v[8*size-1]) v = v | ~m;
    k = (gd + 1) + (rdl + 1);
    if ((off % size) != 0) begin
      e.kind = 1; e.stalls = 0; e.rd = 32'd0;
    end else if (k > TMO) begin
      e.kind = 2; e.stalls = TMO + 1; e.rd = 32'd0;
    end else begin
      e.kind = 0; e.stalls = k + 1; e.rd = wr ? 32'd0 : v;
    end
    return e;
  endfunction

  task automatic issue(input bit wr, input logic [1:0] ss, input logic [2:0] ls,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rw, input int gd, input int rdl);
    exp_t e;
    slv_t s;
    int   n;
    e = model(wr, ss, ls, a, wd, rw, gd, rdl);
    exp_q.push_back(e);
    if (e.kind != 1) begin
      s.gd = gd; s.rdl = rdl; s.rdata = rw;
      slv_q.push_back(s);
    end
    @(posedge clk); #2;
    mem_write = wr; mem_read = !wr; s_sel = ss; ld_sel = ls; addr = a; writeData = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 40);
    if (stall) begin
      total++; bad++;
      $display("FAIL txn_bound: stall=%b after %0d cycles, want 0", stall, n);
    end
    @(posedge clk); #2;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Bus responder: grant after gd cycles of REQ, ack after rdl more cycles; junk rvalid outside WAIT.
  initial begin
    int   phase;
    int   cnt;
    slv_t s;
    phase = 0; cnt = 0;
    s.gd = 0; s.rdl = 0; s.rdata = 32'd0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
    forever begin
      @(posedge clk); #3;
      bus_if.bus_gnt    = man_gnt;
      bus_if.bus_rvalid = man_rvalid;
      bus_if.bus_rdata  = mon_en ? $urandom : man_rdata;
      if (phase != 0 && !stall) phase = 0;
      if (phase == 0 && bus_if.bus_req && slv_q.size() > 0) begin
        s = slv_q.pop_front(); cnt = s.gd; phase = 1;
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          bus_if.bus_gnt = 1'b1; phase = 2; cnt = s.rdl;
        end else begin
          cnt--;
          if (mon_en && ($urandom % 4 == 0)) bus_if.bus_rvalid = 1'b1;
        end
      end else if (phase == 2) begin
        if (cnt == 0) begin
          bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = s.rdata; phase = 0;
        end else cnt--;
      end else if (mon_en && !bus_if.bus_req && ($urandom % 8 == 0)) begin
        bus_if.bus_rvalid = 1'b1;
      end
    end
  end

  // Monitor: checks bus fields while requesting and pops the scoreboard at DONE / misaligned.
  initial begin
    bit   prev_stall;
    bit   prev_req;
    int   stalls;
    int   reqs;
    exp_t e;
    prev_stall = 1'b0; prev_req = 1'b0; stalls = 0; reqs = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0; prev_req = 1'b0; stalls = 0; reqs = 0;
      end else begin
        if (bus_if.bus_req && !prev_req) reqs++;
        if (bus_if.bus_req) begin
          if (exp_q.size() == 0) check("spurious_req", 32'd1, 32'd0);
          else begin
            check("bus_addr", bus_if.bus_addr, exp_q[0].baddr);
            check("bus_be", 32'(bus_if.bus_be), 32'(exp_q[0].be));
            check("bus_we", 32'(bus_if.bus_we), 32'(!exp_q[0].is_ld));
            if (!exp_q[0].is_ld) check("bus_wdata", bus_if.bus_wdata, exp_q[0].wdata);
          end
        end
        if (misaligned || (prev_stall && !stall && (mem_read || mem_write))) begin
          if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            if (misaligned) begin
              check("misal_kind", 32'd1, 32'(e.kind));
              check("misal_stall", 32'(stall), 32'd0);
              check("misal_rd", rd_data, 32'd0);
              check("misal_reqs", 32'(reqs), 32'd0);
              check("misal_err", 32'(bus_err), 32'd0);
            end else begin
              check("done_kind_misal", 32'(e.kind == 1), 32'd0);
              check("bus_err", 32'(bus_err), 32'(e.kind == 2));
              if (e.is_ld) check("rd_data", rd_data, e.rd);
              check("stall_cycles", 32'(stalls), 32'(e.stalls));
              check("req_count", 32'(reqs), 32'd1);
              check("req_dropped", 32'(bus_if.bus_req), 32'd0);
            end
          end
          stalls = 0; reqs = 0;
        end else if (bus_err) begin
          check("stray_bus_err", 32'd1, 32'd0);
        end
        if (stall) stalls++;
        prev_stall = stall;
        prev_req   = bus_if.bus_req;
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_misal", 32'(misaligned), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_rd", rd_data, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    mon_en = 1'b1;

    issue(1'b0, 2'd0, 3'b010, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 0, 0);
    issue(1'b0, 2'd0, 3'b000, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 0);
    issue(1'b0, 2'd0, 3'b100, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 0);
    issue(1'b1, 2'b01, 3'b000, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 0, 0);
    issue(1'b0, 2'd0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0, 0);
    issue(1'b0, 2'd0, 3'b001, 32'h0000_0302, 32'd0, 32'h8765_4321, 4, 1);
    issue(1'b0, 2'd0, 3'b010, 32'h0000_0400, 32'd0, 32'hDEAD_BEEF, 100, 0);

    // Reset while waiting for the response, then a late rvalid.
    @(posedge clk); #2;
    mon_en = 1'b0;
    mem_read = 1'b1; ld_sel = 3'b010; addr = 32'h0000_0040;
    @(posedge clk); #2;
    man_gnt = 1'b1;
    @(posedge clk); #2;
    man_gnt = 1'b0;
    @(negedge clk);
    check("wait_stall", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_wait_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_wait_stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    man_rdata = 32'h5555_AAAA; man_rvalid = 1'b1;
    @(negedge clk);
    check("late_rvalid_stall", 32'(stall), 32'd0);
    @(posedge clk); #2;
    man_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_rd", rd_data, 32'd0);
    check("late_rvalid_req", 32'(bus_if.bus_req), 32'd0);
    mon_en = 1'b1;

    repeat (200) begin
      a = $urandom;
      r = int'($urandom % 4);
      if (r == 1) a[0] = 1'b0;
      else if (r >= 2) a[1:0] = 2'b00;
      issue(bit'($urandom % 3 == 0), 2'($urandom), 3'($urandom), a, $urandom, $urandom,
            int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit directly downstream of the core's ALU address path; replaces the single-cycle data memory with a multi-cycle word bus.
- Takes the core's mem_read/mem_write, s_sel/ld_sel and the ALU address, and drives a req/gnt/rvalid word bus with byte-lane strobes.
- Stalls the core until the access completes, then returns the sign/zero-extended load data for register writeback.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before the access is aborted with bus_err (8-bit counter, 1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  core load request (level, held while stall=1)
- mem_write  in  1  core store request (level, held while stall=1)
- addr  in  32  byte address from ALU
- writeData  in  32  store data (rs2)
- s_sel  in  2  store size: 00 SB, 01 SH, 10 SW (11 treated as SW)
- ld_sel  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others treated as LW)
- rd_data  out  32  formatted load result, valid in DONE cycle
- stall  out  1  freeze PC/regfile write
- misaligned  out  1  one-cycle pulse, access rejected
- bus_err  out  1  one-cycle pulse, timeout abort
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address ({addr[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack valid
- bus_rdata  in  32  read word

Behaviour:
- Reset (async): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops bus_req immediately; the pending response is discarded.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_write or mem_read (write wins if both) and aligned: latch addr/be/we/wdata/ld_sel, go to REQ.
  - stall=1 combinationally in this same cycle.
- Alignment rules:
  - Half accesses need addr[0]=0; word accesses need addr[1:0]=00.
  - Misaligned: stay IDLE, misaligned=1 for that cycle, stall=0, rd_data=0, no bus activity.
- REQ:
  - bus_req=1; bus_addr/bus_we/bus_be/bus_wdata held stable from latched values.
  - On bus_gnt go to WAIT (gnt may come in the first REQ cycle).
  - stall=1.
- WAIT:
  - bus_req=0, stall=1.
  - On bus_rvalid: loads register the formatted rd_data; go to DONE.
  - Stores also wait for rvalid as the write ack; bus_rdata is ignored.
- DONE:
  - stall=0 for exactly one cycle; rd_data held.
  - Go to IDLE unconditionally. The request is not re-sampled in DONE, which prevents re-launching the instruction that just completed.
- Timeout:
  - Counter clears on entry to REQ and increments each REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES: go to DONE with rd_data=0, bus_err=1 for that DONE cycle, bus_req dropped.
- Byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0] (addr[1] selects half); SW 1111.
- bus_wdata: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
- Load format:
  - Select byte by addr[1:0] or half by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
- Latency with gnt in the first REQ cycle and rvalid one cycle later: 3 stall cycles + 1 DONE cycle.
- rvalid while in IDLE/REQ is ignored.

Test Plan:
- LW at addr 0x100; gnt same cycle; rvalid next cycle with 0xCAFEF00D -> bus_addr=0x100, be=1111, stall high 3 cycles, DONE rd_data=0xCAFEF00D.
- LB at addr 0x103 with rdata 0x80112233 -> be=1000, rd_data=0xFFFFFF80. LBU same access -> 0x00000080.
- SH at addr 0x202, writeData 0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, completes on rvalid.
- LW at addr 0x101 -> misaligned pulse, stall=0, bus_req never asserted.
- LH with gnt delayed 4 cycles -> bus_req/addr/be stable throughout, single DONE cycle, no second request.
- TIMEOUT_CYCLES=8, gnt never asserted -> bus_err at cycle 8, rd_data=0, return to IDLE.
- Reset asserted in WAIT -> bus_req and stall 0 immediately; a late rvalid is ignored.
